// File: rtl/gba_pixel_capture.sv
// GBA PPU pixel capture: converts the BGR555 pixel stream into RGB666 frame-buffer writes,
// tracking column/row from the vsync/hsync strobes and counting pixels that cannot be placed.
module gba_pixel_capture #(
   parameter int WIDTH  = 240,
   parameter int HEIGHT = 160
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic        ppu_vsync,
   input  logic        ppu_hsync,
   input  logic        ppu_valid,
   input  logic [14:0] ppu_pixel,
   output logic [17:0] pixel_data,
   output logic [7:0]  pixel_x,
   output logic [7:0]  pixel_y,
   output logic        pixel_we,
   output logic        frame_done,
   output logic [15:0] drop_cnt,
   output logic        short_line
);

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      LINE       = 2'd1,
      HBLANK     = 2'd2,
      VBLANK     = 2'd3
   } state_t;

   localparam logic [8:0] X_END  = 9'(WIDTH);
   localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
   localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

   // Replicating each channel MSB into the new LSB maps 0x00->0x00 and 0x1F->0x3F.
   function automatic logic [17:0] bgr555_to_rgb666(input logic [14:0] p);
      return {p[4:0], p[4], p[9:5], p[9], p[14:10], p[14]};
   endfunction

   state_t      state_r;
   state_t      state_n_s;
   logic [8:0]  x_r;
   logic [8:0]  x_n_s;
   logic [7:0]  y_r;
   logic [7:0]  y_n_s;
   logic        wr_s;
   logic [8:0]  wx_s;
   logic [7:0]  wy_s;
   logic        drop_s;
   logic        done_s;
   logic        short_s;
   logic        line_full_s;
   state_t      run_state_s;

   logic [17:0] pixel_data_r;
   logic [7:0]  pixel_x_r;
   logic [7:0]  pixel_y_r;
   logic        pixel_we_r;
   logic        frame_done_r;
   logic [15:0] drop_cnt_r;
   logic        short_line_r;

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r <= WAIT_FRAME;
      end else begin
         state_r <= state_n_s;
      end
   end

   // A write to the last column moves the line into HBLANK.
   assign line_full_s = wr_s && (wx_s == X_LAST);
   assign run_state_s = line_full_s ? HBLANK : LINE;

   // Next-state decode; vsync outranks hsync, which outranks pixel data.
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         WAIT_FRAME: begin
            if (ppu_vsync && enable) begin
               state_n_s = run_state_s;
            end else begin
               state_n_s = WAIT_FRAME;
            end
         end
         LINE, HBLANK: begin
            if (ppu_vsync) begin
               state_n_s = enable ? run_state_s : WAIT_FRAME;
            end else if (ppu_hsync) begin
               state_n_s = (y_r == Y_LAST) ? VBLANK : run_state_s;
            end else if (line_full_s) begin
               state_n_s = HBLANK;
            end else begin
               state_n_s = state_r;
            end
         end
         VBLANK: begin
            if (ppu_vsync) begin
               state_n_s = enable ? run_state_s : WAIT_FRAME;
            end else begin
               state_n_s = VBLANK;
            end
         end
         default: state_n_s = WAIT_FRAME;
      endcase
   end

   // Output/datapath decode: write target, counter updates and event strobes.
   always_comb begin
      wr_s    = 1'b0;
      wx_s    = x_r;
      wy_s    = y_r;
      x_n_s   = x_r;
      y_n_s   = y_r;
      drop_s  = 1'b0;
      done_s  = 1'b0;
      short_s = 1'b0;
      case (state_r)
         WAIT_FRAME: begin
            if (ppu_vsync && enable) begin
               wx_s  = 9'd0;
               wy_s  = 8'd0;
               x_n_s = 9'd0;
               y_n_s = 8'd0;
               wr_s  = ppu_valid;
            end else begin
               wr_s = 1'b0;
            end
         end
         LINE, HBLANK: begin
            if (ppu_vsync) begin
               // Early vsync aborts the frame; a coincident pixel lands at (0,0).
               short_s = 1'b1;
               wx_s    = 9'd0;
               wy_s    = 8'd0;
               x_n_s   = 9'd0;
               y_n_s   = 8'd0;
               wr_s    = ppu_valid && enable;
            end else if (ppu_hsync) begin
               short_s = (state_r == LINE) && (x_r < X_END);
               if (y_r == Y_LAST) begin
                  done_s = 1'b1;
                  drop_s = ppu_valid;
                  x_n_s  = 9'd0;
               end else begin
                  wx_s  = 9'd0;
                  wy_s  = y_r + 8'd1;
                  x_n_s = 9'd0;
                  y_n_s = y_r + 8'd1;
                  wr_s  = ppu_valid;
               end
            end else if (ppu_valid) begin
               wr_s   = (state_r == LINE);
               drop_s = (state_r == HBLANK);
            end else begin
               wr_s = 1'b0;
            end
         end
         VBLANK: begin
            if (ppu_vsync) begin
               wx_s  = 9'd0;
               wy_s  = 8'd0;
               x_n_s = 9'd0;
               y_n_s = 8'd0;
               wr_s  = ppu_valid && enable;
            end else begin
               drop_s = ppu_valid;
            end
         end
         default: begin
            x_n_s = 9'd0;
            y_n_s = 8'd0;
         end
      endcase
      if (wr_s) begin
         x_n_s = wx_s + 9'd1;
      end else begin
         x_n_s = x_n_s;
      end
   end

   // Column/row counters.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         x_r <= 9'd0;
         y_r <= 8'd0;
      end else begin
         x_r <= x_n_s;
         y_r <= y_n_s;
      end
   end

   // Frame-buffer write port; data/address hold between strobes.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pixel_we_r   <= 1'b0;
         pixel_data_r <= 18'd0;
         pixel_x_r    <= 8'd0;
         pixel_y_r    <= 8'd0;
      end else begin
         pixel_we_r <= wr_s;
         if (wr_s) begin
            pixel_data_r <= bgr555_to_rgb666(ppu_pixel);
            pixel_x_r    <= wx_s[7:0];
            pixel_y_r    <= wy_s;
         end
      end
   end

   // Status: frame completion pulse, saturating drop counter, sticky short-line flag.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         frame_done_r <= 1'b0;
         drop_cnt_r   <= 16'd0;
         short_line_r <= 1'b0;
      end else begin
         frame_done_r <= done_s;
         if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
         end
         short_line_r <= short_line_r | short_s;
      end
   end

   assign pixel_data = pixel_data_r;
   assign pixel_x    = pixel_x_r;
   assign pixel_y    = pixel_y_r;
   assign pixel_we   = pixel_we_r;
   assign frame_done = frame_done_r;
   assign drop_cnt   = drop_cnt_r;
   assign short_line = short_line_r;

endmodule

// File: doc/gba_pixel_capture.md
GBA_PIXEL_CAPTURE -- requirements
Module: gba_pixel_capture

Interface
REQ-001 Parameter WIDTH, default 240, active pixels per line.
REQ-002 Parameter HEIGHT, default 160, active lines per frame.
REQ-003 clk  input  1  system clock; all logic in this domain (same clock as frame-buffer write port).
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  capture enable; sampled only at frame start.
REQ-006 ppu_vsync  input  1  one-cycle strobe: start of frame (line 0 begins).
REQ-007 ppu_hsync  input  1  one-cycle strobe: end of current line, next line begins.
REQ-008 ppu_valid  input  1  one-cycle strobe: ppu_pixel valid this cycle.
REQ-009 ppu_pixel  input  15  BGR555: [4:0] R, [9:5] G, [14:10] B.
REQ-010 pixel_data  output  18  RGB6: [17:12] R, [11:6] G, [5:0] B.
REQ-011 pixel_x  output  8  column of pixel_data, 0..WIDTH-1.
REQ-012 pixel_y  output  8  row of pixel_data, 0..HEIGHT-1.
REQ-013 pixel_we  output  1  one-cycle write strobe for pixel_data/x/y.
REQ-014 frame_done  output  1  one-cycle pulse on completion of line HEIGHT-1.
REQ-015 drop_cnt  output  16  pixels discarded (x overflow or outside active region), saturating.
REQ-016 short_line  output  1  sticky: a line ended with fewer than WIDTH pixels.

Function
REQ-017 States: WAIT_FRAME, LINE, HBLANK, VBLANK; internal counters x (0..WIDTH), y (0..HEIGHT-1).
REQ-018 WAIT_FRAME: ppu_vsync with enable=1 -> LINE, x=0, y=0; vsync with enable=0 stays; pixels/hsync ignored, not counted.
REQ-019 LINE: each ppu_valid writes one pixel at (x,y), then x+1; when x reaches WIDTH -> HBLANK.
REQ-020 HBLANK: ppu_valid not written, drop_cnt+1.
REQ-021 ppu_hsync in LINE or HBLANK: if y==HEIGHT-1 -> VBLANK and frame_done pulse next cycle; else y+1, x=0, -> LINE.
REQ-022 ppu_hsync in LINE with x<WIDTH sets short_line; unwritten columns keep prior frame-buffer contents.
REQ-023 VBLANK: ppu_valid increments drop_cnt; hsync ignored; vsync -> LINE (x=0,y=0) if enable=1, else WAIT_FRAME.
REQ-024 ppu_vsync in LINE or HBLANK (early frame): abort frame, restart as REQ-023, short_line set, no frame_done.
REQ-025 Priority within one cycle: vsync > hsync > valid; valid coincident with hsync is written at x=0 of new line; valid coincident with vsync is written at (0,0).
REQ-026 enable deassertion mid-frame has no effect until next vsync.
REQ-027 Colour: each 5-bit channel c maps to 6-bit {c, c[4]}; 0x00->0x00, 0x1F->0x3F.
REQ-028 Latency: pixel_we/pixel_data/pixel_x/pixel_y registered, asserted exactly 1 clk after accepted ppu_valid; outputs hold value when pixel_we=0.
REQ-029 At most one pixel_we per clk; back-to-back ppu_valid every cycle sustained without loss.
REQ-030 drop_cnt saturates at 0xFFFF; pixel_x never exceeds WIDTH-1, pixel_y never exceeds HEIGHT-1.

Reset
REQ-031 resetn=0 at a clk edge: state WAIT_FRAME, x=0, y=0, pixel_we=0, frame_done=0, pixel_data=0, pixel_x=0, pixel_y=0, drop_cnt=0, short_line=0.
REQ-032 Reset mid-frame discards the frame; no pixel_we or frame_done in the cycle after reset releases.

Verification
REQ-033 enable=1, vsync, then 160 lines of 240 valids each followed by hsync -> 38400 pixel_we, last at (239,159), one frame_done, drop_cnt=0, short_line=0.
REQ-034 ppu_pixel=0x7FFF -> pixel_data=0x3FFFF; 0x001F -> 0x3F000; 0x7C00 -> 0x0003F, 1 clk later.
REQ-035 Line with 245 valids -> 240 writes, drop_cnt=5; line with 200 valids then hsync -> short_line=1, next pixel at x=0,y+1.
REQ-036 vsync at line 50 -> next valid written at (0,0), no frame_done, short_line=1.
REQ-037 enable=0 at vsync -> no pixel_we for whole frame; enable=1 at following vsync -> capture resumes at (0,0).
REQ-038 resetn low during line 80 for one cycle -> all outputs zero, hsync/valid ignored until next vsync.
